// File: rtl/vregfile_readseq_if.sv
// ---------------------------------------------------------------------------
// vregfile_readseq_if
//
// Purpose: bundles the three handshakes around the vector register file read
// sequencer: the request channel, the register file read port pair and the
// operand output stream.
//
// Modports:
//   master : environment side (issues requests, owns the register file,
//            consumes the operand stream)
//   slave  : sequencer side (vregfile_readseq)
//
// Signals (LRB = LOG2NUMREGS - LOG2NUMBANKS):
//   req_valid/req_ready      request handshake
//   req_areg/req_breg [LRB]  base group for operands a and b
//   req_len [LRB+1]          number of element groups, 0..NUMREGS/NUMBANKS
//   req_stride [LRB]         address increment (VREGFILE_READSEQ_STRIDE_EN only)
//   flush                    synchronous abort
//   a_reg/b_reg              group address replicated to every bank
//   a_en/b_en                read enables, one bit per bank
//   a_readdatain/b_readdatain read data, valid one cycle after enable
//   out_valid/out_ready      operand stream handshake
//   out_a/out_b              operand data (pass-through of read data)
//   out_last                 final group of a request
//
// Optional feature macro: VREGFILE_READSEQ_STRIDE_EN
// ---------------------------------------------------------------------------
interface vregfile_readseq_if #(
  parameter int NUMBANKS     = 1,
  parameter int LOG2NUMBANKS = 0,
  parameter int WIDTH        = 32,
  parameter int LOG2NUMREGS  = 5
);
  localparam int LRB = LOG2NUMREGS - LOG2NUMBANKS;

  logic                      req_valid;
  logic                      req_ready;
  logic [LRB-1:0]            req_areg;
  logic [LRB-1:0]            req_breg;
  logic [LRB:0]              req_len;
`ifdef VREGFILE_READSEQ_STRIDE_EN
  logic [LRB-1:0]            req_stride;
`endif
  logic                      flush;

  logic [NUMBANKS*LRB-1:0]   a_reg;
  logic [NUMBANKS*LRB-1:0]   b_reg;
  logic [NUMBANKS-1:0]       a_en;
  logic [NUMBANKS-1:0]       b_en;
  logic [NUMBANKS*WIDTH-1:0] a_readdatain;
  logic [NUMBANKS*WIDTH-1:0] b_readdatain;

  logic                      out_valid;
  logic                      out_ready;
  logic [NUMBANKS*WIDTH-1:0] out_a;
  logic [NUMBANKS*WIDTH-1:0] out_b;
  logic                      out_last;

  modport master (
`ifdef VREGFILE_READSEQ_STRIDE_EN
    output req_stride,
`endif
    output req_valid, req_areg, req_breg, req_len, flush,
    output a_readdatain, b_readdatain, out_ready,
    input  req_ready, a_reg, b_reg, a_en, b_en,
    input  out_valid, out_a, out_b, out_last
  );

  modport slave (
`ifdef VREGFILE_READSEQ_STRIDE_EN
    input  req_stride,
`endif
    input  req_valid, req_areg, req_breg, req_len, flush,
    input  a_readdatain, b_readdatain, out_ready,
    output req_ready, a_reg, b_reg, a_en, b_en,
    output out_valid, out_a, out_b, out_last
  );
endinterface

// File: rtl/vregfile_readseq.sv
// ---------------------------------------------------------------------------
// vregfile_readseq
//
// Purpose: walks a request of req_len element groups through a banked vector
// register file, reading operands a and b in lock-step and presenting them as
// a valid/ready stream. Read data comes straight from the file one cycle after
// each enable; stalls work because the file holds its data while the enable is
// low, so no skid buffer is needed.
//
// Ports:
//   clk     sole clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     vregfile_readseq_if.slave (request, register file, output stream)
//
// Optional feature macro: VREGFILE_READSEQ_STRIDE_EN
//   defined   : req_stride is latched on acceptance and used as the increment
//   undefined : the group address advances by 1
// ---------------------------------------------------------------------------
module vregfile_readseq #(
  parameter int NUMBANKS     = 1,
  parameter int LOG2NUMBANKS = 0,
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 32,
  parameter int LOG2NUMREGS  = 5
) (
  input logic              clk,
  input logic              resetn,
  vregfile_readseq_if.slave bus
);

  localparam int LRB  = LOG2NUMREGS - LOG2NUMBANKS;
  localparam int BUSW = NUMBANKS * WIDTH;
  localparam logic [LRB:0] REGS_PER_BANK = (LRB+1)'(NUMREGS / NUMBANKS);
  localparam logic [LRB:0] COUNT_ONE     = (LRB+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [LRB-1:0] a_addr_q, a_addr_d;
  logic [LRB-1:0] b_addr_q, b_addr_d;
  logic [LRB:0]   count_q, count_d;
  logic           pend_q, pend_d;
  logic           last_q, last_d;
  logic           req_ready_q, req_ready_d;
  logic [LRB-1:0] stride;
`ifdef VREGFILE_READSEQ_STRIDE_EN
  logic [LRB-1:0] stride_q, stride_d;
  assign stride = stride_q;
`else
  assign stride = LRB'(1);
`endif

  logic issue;
  logic accept;
  logic out_hs;

  // Group address advance modulo the registers held by one bank. Both
  // operands are below REGS_PER_BANK, so one conditional subtract suffices.
  function automatic logic [LRB-1:0] wrap_add(input logic [LRB-1:0] base,
                                              input logic [LRB-1:0] step);
    logic [LRB:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= REGS_PER_BANK) sum = sum - REGS_PER_BANK;
    return sum[LRB-1:0];
  endfunction

  // A new read may be launched only when the previous beat is gone or is
  // leaving this cycle; flush kills the enable in the same cycle.
  assign issue  = (state_q == RUN) && (!pend_q || bus.out_ready) && !bus.flush;
  // flush wins over an offered request: it is dropped, not accepted.
  assign accept = bus.req_valid && req_ready_q && !bus.flush;
  assign out_hs = pend_q && bus.out_ready;

  // NOTE: combinational next-state logic uses blocking assignments and gives
  // every _d signal a default first, so no latch is inferred on any path.
  always_comb begin
    state_d  = state_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    last_d   = last_q;
`ifdef VREGFILE_READSEQ_STRIDE_EN
    stride_d = stride_q;
`endif

    if (bus.flush) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      last_d  = 1'b0;
    end else begin
      if (issue)       pend_d = 1'b1;
      else if (out_hs) pend_d = 1'b0;

      unique case (state_q)
        IDLE: begin
          // A zero-length request is consumed here without leaving IDLE.
          if (accept && (bus.req_len != '0)) begin
            a_addr_d = bus.req_areg;
            b_addr_d = bus.req_breg;
            count_d  = bus.req_len;
`ifdef VREGFILE_READSEQ_STRIDE_EN
            stride_d = bus.req_stride;
`endif
            state_d  = RUN;
          end
        end
        RUN: begin
          if (issue) begin
            a_addr_d = wrap_add(a_addr_q, stride);
            b_addr_d = wrap_add(b_addr_q, stride);
            count_d  = count_q - COUNT_ONE;
            last_d   = (count_q == COUNT_ONE);
            if (count_q == COUNT_ONE) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs && last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_ready_d = (state_d == IDLE);
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      last_q      <= 1'b0;
      req_ready_q <= 1'b0;
`ifdef VREGFILE_READSEQ_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
`ifdef VREGFILE_READSEQ_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  logic [BUSW-1:0] a_data;
  logic [BUSW-1:0] b_data;
  assign a_data = bus.a_readdatain;
  assign b_data = bus.b_readdatain;

  assign bus.req_ready = req_ready_q;
  assign bus.a_reg     = {NUMBANKS{a_addr_q}};
  assign bus.b_reg     = {NUMBANKS{b_addr_q}};
  assign bus.a_en      = {NUMBANKS{issue}};
  assign bus.b_en      = {NUMBANKS{issue}};
  assign bus.out_valid = pend_q;
  assign bus.out_last  = pend_q && last_q;
  assign bus.out_a     = a_data;
  assign bus.out_b     = b_data;

endmodule

// File: tb/tb_vregfile_readseq.sv
// ---------------------------------------------------------------------------
// tb_vregfile_readseq
//
// Directed bench for vregfile_readseq (NUMBANKS=1, NUMREGS=32, WIDTH=32).
// A small register file model returns 0xA000_00rr on port a and 0xB000_00rr
// on port b, one cycle after the enable, holding data while the enable is low.
// Build with +define+VREGFILE_READSEQ_STRIDE_EN to exercise the stride option.
// ---------------------------------------------------------------------------
module tb_vregfile_readseq;

  localparam int NUMBANKS     = 1;
  localparam int LOG2NUMBANKS = 0;
  localparam int WIDTH        = 32;
  localparam int NUMREGS      = 32;
  localparam int LOG2NUMREGS  = 5;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  vregfile_readseq_if #(
    .NUMBANKS(NUMBANKS), .LOG2NUMBANKS(LOG2NUMBANKS),
    .WIDTH(WIDTH), .LOG2NUMREGS(LOG2NUMREGS)
  ) bus ();

  vregfile_readseq #(
    .NUMBANKS(NUMBANKS), .LOG2NUMBANKS(LOG2NUMBANKS), .WIDTH(WIDTH),
    .NUMREGS(NUMREGS), .LOG2NUMREGS(LOG2NUMREGS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: synchronous read, data held while enable is low.
  logic [WIDTH-1:0] a_rd;
  logic [WIDTH-1:0] b_rd;
  initial begin
    a_rd = '0;
    b_rd = '0;
  end
  always @(posedge clk) begin
    if (bus.a_en[0]) a_rd <= 32'hA000_0000 | 32'(bus.a_reg);
    if (bus.b_en[0]) b_rd <= 32'hB000_0000 | 32'(bus.b_reg);
  end
  assign bus.a_readdatain = a_rd;
  assign bus.b_readdatain = b_rd;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    resetn          = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_areg    = '0;
    bus.req_breg    = '0;
    bus.req_len     = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;
`ifdef VREGFILE_READSEQ_STRIDE_EN
    bus.req_stride  = 5'd1;
`endif

    // ---- reset state
    #2;
    check("rst_ready",  bus.req_ready, 0);
    check("rst_a_en",   bus.a_en,      0);
    check("rst_valid",  bus.out_valid, 0);
    check("rst_last",   bus.out_last,  0);
    check("rst_a_reg",  bus.a_reg,     0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tick();
    check("post_rst_ready", bus.req_ready, 1);

    // ---- areg=4 breg=8 len=3, out_ready=1
    bus.req_valid = 1'b1; bus.req_areg = 5'd4; bus.req_breg = 5'd8; bus.req_len = 6'd3;
    tick();
    bus.req_valid = 1'b0;
    check("t1_ready_run", bus.req_ready, 0);
    check("t1_en0",    bus.a_en,  1);
    check("t1_areg0",  bus.a_reg, 4);
    check("t1_breg0",  bus.b_reg, 8);
    check("t1_valid0", bus.out_valid, 0);
    tick();
    check("t1_valid1", bus.out_valid, 1);
    check("t1_outa1",  bus.out_a, 32'hA000_0004);
    check("t1_outb1",  bus.out_b, 32'hB000_0008);
    check("t1_last1",  bus.out_last, 0);
    check("t1_areg1",  bus.a_reg, 5);
    check("t1_breg1",  bus.b_reg, 9);
    tick();
    check("t1_outa2",  bus.out_a, 32'hA000_0005);
    check("t1_outb2",  bus.out_b, 32'hB000_0009);
    check("t1_last2",  bus.out_last, 0);
    check("t1_areg2",  bus.a_reg, 6);
    check("t1_breg2",  bus.b_reg, 10);
    check("t1_en2",    bus.b_en, 1);
    tick();
    check("t1_outa3",  bus.out_a, 32'hA000_0006);
    check("t1_outb3",  bus.out_b, 32'hB000_000A);
    check("t1_last3",  bus.out_last, 1);
    check("t1_en_drain", bus.a_en, 0);
    check("t1_ready_drain", bus.req_ready, 0);
    tick();
    check("t1_valid_end", bus.out_valid, 0);
    check("t1_ready_end", bus.req_ready, 1);

    // ---- wrap-around: areg=30 len=4 -> 30,31,0,1
    bus.req_valid = 1'b1; bus.req_areg = 5'd30; bus.req_breg = 5'd0; bus.req_len = 6'd4;
    tick();
    bus.req_valid = 1'b0;
    check("t2_areg0", bus.a_reg, 30);
    tick();
    check("t2_areg1", bus.a_reg, 31);
    check("t2_outa1", bus.out_a, 32'hA000_001E);
    tick();
    check("t2_areg2", bus.a_reg, 0);
    check("t2_outa2", bus.out_a, 32'hA000_001F);
    tick();
    check("t2_areg3", bus.a_reg, 1);
    check("t2_outa3", bus.out_a, 32'hA000_0000);
    check("t2_last3", bus.out_last, 0);
    tick();
    check("t2_outa4", bus.out_a, 32'hA000_0001);
    check("t2_last4", bus.out_last, 1);
    tick();
    check("t2_valid_end", bus.out_valid, 0);

    // ---- stall: areg=12 len=4, out_ready low for 3 cycles during beat 2
    bus.req_valid = 1'b1; bus.req_areg = 5'd12; bus.req_breg = 5'd16; bus.req_len = 6'd4;
    tick();
    bus.req_valid = 1'b0;
    check("t3_areg0", bus.a_reg, 12);
    tick();
    check("t3_outa1", bus.out_a, 32'hA000_000C);
    tick();
    check("t3_outa2", bus.out_a, 32'hA000_000D);
    bus.out_ready = 1'b0;
    #1;
    check("t3_stall_en", bus.a_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_valid", bus.out_valid, 1);
      check("t3_stall_outa",  bus.out_a, 32'hA000_000D);
      check("t3_stall_en_h",  bus.a_en, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("t3_resume_en",   bus.a_en, 1);
    check("t3_resume_areg", bus.a_reg, 14);
    tick();
    check("t3_outa3", bus.out_a, 32'hA000_000E);
    check("t3_last3", bus.out_last, 0);
    tick();
    check("t3_outa4", bus.out_a, 32'hA000_000F);
    check("t3_last4", bus.out_last, 1);
    tick();
    check("t3_valid_end", bus.out_valid, 0);
    check("t3_ready_end", bus.req_ready, 1);

    // ---- flush in the cycle of beat 2
    bus.req_valid = 1'b1; bus.req_areg = 5'd20; bus.req_breg = 5'd24; bus.req_len = 6'd4;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t4_outa1", bus.out_a, 32'hA000_0014);
    tick();
    check("t4_outa2", bus.out_a, 32'hA000_0015);
    bus.flush = 1'b1;
    #1;
    check("t4_flush_en", bus.a_en, 0);
    tick();
    bus.flush = 1'b0;
    check("t4_flush_valid", bus.out_valid, 0);
    check("t4_flush_ready", bus.req_ready, 1);
    check("t4_flush_en2",   bus.a_en, 0);
    tick();
    check("t4_flush_en3",   bus.b_en, 0);
    check("t4_flush_valid3", bus.out_valid, 0);

    // ---- flush wins over an offered request
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_areg = 5'd3; bus.req_len = 6'd2;
    tick();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    check("t5_prio_en",    bus.a_en, 0);
    check("t5_prio_ready", bus.req_ready, 1);
    tick();
    check("t5_prio_valid", bus.out_valid, 0);

    // ---- len=0 request is consumed silently
    bus.req_valid = 1'b1; bus.req_areg = 5'd7; bus.req_len = 6'd0;
    tick();
    bus.req_valid = 1'b0;
    check("t6_len0_en",    bus.a_en, 0);
    check("t6_len0_valid", bus.out_valid, 0);
    check("t6_len0_ready", bus.req_ready, 1);
    tick();
    check("t6_len0_en2",   bus.a_en, 0);
    check("t6_len0_ready2", bus.req_ready, 1);

    // ---- stride: areg=2 len=3 (stride 3 when enabled, else fixed 1)
    bus.req_valid = 1'b1; bus.req_areg = 5'd2; bus.req_breg = 5'd2; bus.req_len = 6'd3;
`ifdef VREGFILE_READSEQ_STRIDE_EN
    bus.req_stride = 5'd3;
`endif
    tick();
    bus.req_valid = 1'b0;
    check("t7_areg0", bus.a_reg, 2);
    tick();
`ifdef VREGFILE_READSEQ_STRIDE_EN
    check("t7_areg1", bus.a_reg, 5);
    tick();
    check("t7_areg2", bus.a_reg, 8);
`else
    check("t7_areg1", bus.a_reg, 3);
    tick();
    check("t7_areg2", bus.a_reg, 4);
`endif
    tick();
    check("t7_last", bus.out_last, 1);
    tick();
    check("t7_valid_end", bus.out_valid, 0);
`ifdef VREGFILE_READSEQ_STRIDE_EN
    bus.req_stride = 5'd1;
`endif

    // ---- reset mid-request discards it
    bus.req_valid = 1'b1; bus.req_areg = 5'd9; bus.req_breg = 5'd9; bus.req_len = 6'd5;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t8_valid_pre", bus.out_valid, 1);
    resetn = 1'b0;
    #1;
    check("t8_rst_valid", bus.out_valid, 0);
    check("t8_rst_en",    bus.a_en, 0);
    check("t8_rst_ready", bus.req_ready, 0);
    check("t8_rst_areg",  bus.a_reg, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("t8_post_ready", bus.req_ready, 1);
    check("t8_post_en",    bus.a_en, 0);
    tick();
    check("t8_post_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vregfile_readseq.md
VREGFILE_READSEQ -- requirements
Module: vregfile_readseq

Interface
REQ-001 SHALL have parameter NUMBANKS, default 1: banks (lanes) in the attached vector register file.
REQ-002 SHALL have parameter LOG2NUMBANKS, default 0: log2 of NUMBANKS.
REQ-003 SHALL have parameter WIDTH, default 32: bits per bank element.
REQ-004 SHALL have parameter NUMREGS, default 32: total registers; NUMREGSPERBANK = NUMREGS/NUMBANKS.
REQ-005 SHALL have parameter LOG2NUMREGS, default 5; LOG2NUMREGSPERBANK (LRB) = LOG2NUMREGS-LOG2NUMBANKS.
REQ-006 SHALL have port clk, input, 1: sole clock; all state is rising-edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, 1: read request offered.
REQ-009 SHALL have port req_ready, output, 1: request accepted when req_valid & req_ready.
REQ-010 SHALL have ports req_areg and req_breg, input, LRB each: base register for operands a and b.
REQ-011 SHALL have port req_len, input, LRB+1: element groups to read, 0..NUMREGSPERBANK.
REQ-012 SHALL have port flush, input, 1: synchronous abort of the current request.
REQ-013 SHALL have ports a_reg and b_reg, output, NUMBANKS*LRB each: the same group address replicated to every bank.
REQ-014 SHALL have ports a_en and b_en, output, NUMBANKS each: read enables, all bits equal.
REQ-015 SHALL have ports a_readdatain and b_readdatain, input, NUMBANKS*WIDTH each: register file read data, valid one cycle after enable, held while enable is low.
REQ-016 SHALL have port out_valid, output, 1, and port out_ready, input, 1: operand stream handshake.
REQ-017 SHALL have ports out_a and out_b, output, NUMBANKS*WIDTH each, driven directly by a_readdatain and b_readdatain.
REQ-018 SHALL have port out_last, output, 1: marks the final group of a request.

Function
REQ-019 SHALL implement states IDLE, RUN and DRAIN.
REQ-020 IDLE: SHALL hold req_ready=1; on acceptance with req_len>0, SHALL latch the bases, set count=req_len and go to RUN.
REQ-021 A request accepted with req_len=0 SHALL be consumed with no reads, no output, and the block SHALL stay in IDLE.
REQ-022 SHALL define issue = (state==RUN) & (!pend | out_ready); a_en and b_en SHALL equal issue on all bits.
REQ-023 On issue, the group address SHALL advance by the stride modulo NUMREGSPERBANK, and count SHALL decrement.
REQ-024 pend SHALL be set on issue and cleared when out_valid & out_ready occur without issue; out_valid SHALL equal pend.
REQ-025 out_last SHALL equal pend & lastflag, where lastflag is registered on the issue with count==1.
REQ-026 The issue with count==1 SHALL move the state to DRAIN; DRAIN SHALL go to IDLE on the out_last handshake.
REQ-027 req_ready SHALL be 0 in RUN and DRAIN; back-to-back requests therefore have one idle cycle between them.
REQ-028 With out_ready held at 1, throughput SHALL be one group per cycle, and first-data latency SHALL be 1 cycle after acceptance.
REQ-029 When out_ready=0 with pend=1, enables SHALL stay low; the file holds its data, so out_a and out_b SHALL remain stable.
REQ-030 flush SHALL force IDLE, clear pend and lastflag, and deassert enables in that same cycle; flush SHALL take priority over req_valid.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, pend=0, lastflag=0, count=0, addresses=0, a_en=b_en=0, out_valid=0, out_last=0 and req_ready=0.
REQ-032 req_ready SHALL assert in the first cycle after reset is released; a reset mid-request SHALL discard that request.

Configuration
REQ-033 Macro VREGFILE_READSEQ_STRIDE_EN SHALL, when defined, add input req_stride (LRB bits), latched on acceptance and used as the address increment.
REQ-034 Without VREGFILE_READSEQ_STRIDE_EN, req_stride SHALL not exist and the stride SHALL be fixed at 1.

Verification
REQ-035 Reset, then request areg=4, breg=8, len=3 with out_ready=1: reads SHALL go to a_reg groups 4,5,6 and b_reg groups 8,9,10 on consecutive cycles, with out_last on the third beat.
REQ-036 Request areg=30, len=4 (NUMREGS=32, NUMBANKS=1): addresses SHALL be 30,31,0,1.
REQ-037 Drop out_ready for 3 cycles during beat 2 of len=4: enables SHALL stay low, out_a SHALL stay stable, and exactly 4 beats SHALL be delivered in order.
REQ-038 Assert flush in the cycle of beat 2: out_valid=0 on the next cycle, req_ready=1, and no further reads.
REQ-039 Request with len=0: no enables, no out_valid, and req_ready SHALL stay 1.
REQ-040 With STRIDE_EN, request areg=2, stride=3, len=3: addresses SHALL be 2,5,8; without STRIDE_EN, addresses SHALL be 2,3,4.
